// File: rtl/canny_hysteresis.sv
// canny_hysteresis: double threshold plus single-pass 3x3 hysteresis on the NMS stream, 3-clk latency.
// Define HYST_EDGE_CNT_EN to add the per-frame edge counter outputs (edge_cnt / edge_cnt_vld).
module canny_hysteresis #(
  parameter int   IMG_W     = 640,
  parameter int   TH_LOW    = 40,
  parameter int   TH_HIGH   = 100,
  parameter logic VS_ACTIVE = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  NMS_data,
  input  logic        NMS_hs,
  input  logic        NMS_vs,
  input  logic        NMS_de,
  output logic [7:0]  edge_data,
  output logic        edge_hs,
  output logic        edge_vs,
  output logic        edge_de
`ifdef HYST_EDGE_CNT_EN
  ,
  output logic [31:0] edge_cnt,
  output logic        edge_cnt_vld
`endif
);

  localparam int            CW      = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int            RW      = 16;
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
  localparam logic [8:0]    TH_LO9  = 9'(TH_LOW);
  localparam logic [8:0]    TH_HI9  = 9'(TH_HIGH);

  typedef enum logic [1:0] {
    C_NONE   = 2'd0,
    C_WEAK   = 2'd1,
    C_STRONG = 2'd2
  } code_t;

  // Stage 0: classification
  code_t code_d, code0_q;
  logic  de0_q, hs0_q, vs0_q;

  always_comb begin
    code_d = C_NONE;
    if (NMS_de) begin
      if ({1'b0, NMS_data} >= TH_HI9) begin
        code_d = C_STRONG;
      end else if ({1'b0, NMS_data} >= TH_LO9) begin
        code_d = C_WEAK;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code0_q <= C_NONE;
      de0_q   <= 1'b0;
      hs0_q   <= 1'b0;
      vs0_q   <= 1'b0;
    end else begin
      code0_q <= code_d;
      de0_q   <= NMS_de;
      hs0_q   <= NMS_hs;
      vs0_q   <= NMS_vs;
    end
  end

  // Stage 1: line buffers, counters and the 3x3 window
  code_t         lb1 [IMG_W];
  code_t         lb2 [IMG_W];
  code_t         lb1_rd, lb2_rd, up1, up2;
  code_t         win_q [3][3];
  code_t         win_d [3][3];
  logic [CW-1:0] col_cnt_q, col_cnt_d;
  logic [RW-1:0] row_cnt_q, row_cnt_d;
  logic          de1_q, hs1_q, vs1_q;
  logic          fs0, de_fall, first_col;

  always_comb begin
    fs0       = (vs0_q == VS_ACTIVE) && (vs1_q != VS_ACTIVE);
    de_fall   = de1_q && !de0_q;
    first_col = (col_cnt_q == '0);

    col_cnt_d = col_cnt_q;
    if (de_fall) begin
      col_cnt_d = '0;
    end else if (de0_q && (col_cnt_q != COL_MAX)) begin
      col_cnt_d = col_cnt_q + CW'(1);
    end

    row_cnt_d = row_cnt_q;
    if (fs0) begin
      row_cnt_d = '0;
    end else if (de_fall && (row_cnt_q != '1)) begin
      row_cnt_d = row_cnt_q + RW'(1);
    end

    // A frame start coinciding with a pixel makes that pixel row 0, so mask with fs0 as well.
    lb1_rd = lb1[col_cnt_q];
    lb2_rd = lb2[col_cnt_q];
    up1    = (fs0 || (row_cnt_q == '0))     ? C_NONE : lb1_rd;
    up2    = (fs0 || (row_cnt_q < RW'(2)))  ? C_NONE : lb2_rd;
  end

  always_comb begin
    win_d = win_q;
    if (de0_q) begin
      for (int unsigned r = 0; r < 3; r++) begin
        win_d[r][0] = first_col ? C_NONE : win_q[r][1];
        win_d[r][1] = first_col ? C_NONE : win_q[r][2];
      end
      win_d[0][2] = up2;
      win_d[1][2] = up1;
      win_d[2][2] = code0_q;
    end
  end

  always_ff @(posedge clk) begin
    if (de0_q) begin
      lb1[col_cnt_q] <= code0_q;
      lb2[col_cnt_q] <= lb1_rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt_q <= '0;
      row_cnt_q <= '0;
      de1_q     <= 1'b0;
      hs1_q     <= 1'b0;
      vs1_q     <= 1'b0;
      for (int unsigned r = 0; r < 3; r++) begin
        for (int unsigned c = 0; c < 3; c++) begin
          win_q[r][c] <= C_NONE;
        end
      end
    end else begin
      col_cnt_q <= col_cnt_d;
      row_cnt_q <= row_cnt_d;
      de1_q     <= de0_q;
      hs1_q     <= hs0_q;
      vs1_q     <= vs0_q;
      win_q     <= win_d;
    end
  end

  // Stage 2: hysteresis decision on the window centre
  logic       nb_strong, is_edge;
  logic [7:0] edge_data_d;

  always_comb begin
    nb_strong = 1'b0;
    for (int unsigned r = 0; r < 3; r++) begin
      for (int unsigned c = 0; c < 3; c++) begin
        if (!((r == 1) && (c == 1)) && (win_q[r][c] == C_STRONG)) begin
          nb_strong = 1'b1;
        end
      end
    end
    is_edge     = (win_q[1][1] == C_STRONG) || ((win_q[1][1] == C_WEAK) && nb_strong);
    edge_data_d = (de1_q && is_edge) ? 8'hFF : 8'h00;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_data <= '0;
      edge_hs   <= 1'b0;
      edge_vs   <= 1'b0;
      edge_de   <= 1'b0;
    end else begin
      edge_data <= edge_data_d;
      edge_hs   <= hs1_q;
      edge_vs   <= vs1_q;
      edge_de   <= de1_q;
    end
  end

`ifdef HYST_EDGE_CNT_EN
  logic [31:0] ecnt_q;
  logic        evs_d1_q, ofs, hit;

  always_comb begin
    ofs = (edge_vs == VS_ACTIVE) && (evs_d1_q != VS_ACTIVE);
    hit = edge_de && (edge_data == 8'hFF);
  end

  // An edge pixel arriving with the frame start belongs to the new frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ecnt_q       <= '0;
      evs_d1_q     <= 1'b0;
      edge_cnt     <= '0;
      edge_cnt_vld <= 1'b0;
    end else begin
      evs_d1_q     <= edge_vs;
      edge_cnt_vld <= ofs;
      if (ofs) begin
        edge_cnt <= ecnt_q;
        ecnt_q   <= hit ? 32'd1 : 32'd0;
      end else if (hit) begin
        ecnt_q <= ecnt_q + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_canny_hysteresis.sv
// Scoreboard bench for canny_hysteresis: frame-level reference model feeds expectation queues,
// a negedge monitor pops and compares sync, pixel data and (when enabled) frame edge counts.
module tb_canny_hysteresis;

  localparam int IMG_W   = 48;
  localparam int H_MAX   = 48;
  localparam int TH_LOW  = 40;
  localparam int TH_HIGH = 100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] NMS_data = '0;
  logic       NMS_hs = 1'b0, NMS_vs = 1'b0, NMS_de = 1'b0;
  logic [7:0] edge_data;
  logic       edge_hs, edge_vs, edge_de;
`ifdef HYST_EDGE_CNT_EN
  logic [31:0] edge_cnt;
  logic        edge_cnt_vld;
`endif

  canny_hysteresis #(
    .IMG_W    (IMG_W),
    .TH_LOW   (TH_LOW),
    .TH_HIGH  (TH_HIGH),
    .VS_ACTIVE(1'b1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .NMS_data (NMS_data),
    .NMS_hs   (NMS_hs),
    .NMS_vs   (NMS_vs),
    .NMS_de   (NMS_de),
    .edge_data(edge_data),
    .edge_hs  (edge_hs),
    .edge_vs  (edge_vs),
    .edge_de  (edge_de)
`ifdef HYST_EDGE_CNT_EN
    ,
    .edge_cnt    (edge_cnt),
    .edge_cnt_vld(edge_cnt_vld)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [2:0] sync_q [$];
  logic [7:0] data_q [$];
  int         cnt_q  [$];
  logic       mute = 1'b1;
  int         rst_hold = 0;
  logic       prev_vs = 1'b0;
  int         edges_fs = 0;
  logic       cnt_dc = 1'b0;

  logic [7:0] frm  [H_MAX][IMG_W];
  logic [7:0] expo [H_MAX][IMG_W];
  int         fw, fh;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int code_at(input int c, input int r);
    int v;
    if (c < 0 || r < 0) return 0;
    v = int'(frm[r][c]);
    if (v >= TH_HIGH) return 2;
    if (v >= TH_LOW) return 1;
    return 0;
  endfunction

  // Output (x,y) is the decision for input (x-1,y-1); out-of-image neighbours count as none.
  task automatic build_expected();
    int cc;
    bit nb;
    for (int y = 0; y < fh; y++) begin
      for (int x = 0; x < fw; x++) begin
        expo[y][x] = 8'h00;
        if (x > 0 && y > 0) begin
          cc = code_at(x - 1, y - 1);
          nb = 0;
          for (int dy = -1; dy <= 1; dy++)
            for (int dx = -1; dx <= 1; dx++)
              if (!(dx == 0 && dy == 0) && code_at(x - 1 + dx, y - 1 + dy) == 2) nb = 1;
          if (cc == 2 || (cc == 1 && nb)) expo[y][x] = 8'hFF;
        end
      end
    end
  endtask

  task automatic clear_frame();
    for (int y = 0; y < H_MAX; y++)
      for (int x = 0; x < IMG_W; x++)
        frm[y][x] = 8'h00;
  endtask

  task automatic step(input logic [7:0] d, input logic hs, input logic vs,
                      input logic de, input logic [7:0] expd);
    @(posedge clk);
    #1;
    NMS_data = d;
    NMS_hs   = hs;
    NMS_vs   = vs;
    NMS_de   = de;
    if (rst_hold > 0) begin
      rst_hold--;
      if (rst_hold == 0) rst_n = 1'b1;
    end
    sync_q.push_back({hs, vs, de});
    if (!mute) begin
      if (vs && !prev_vs) begin
        cnt_q.push_back(cnt_dc ? -1 : edges_fs);
        edges_fs = 0;
        cnt_dc   = 1'b0;
      end
      if (de) begin
        data_q.push_back(expd);
        if (expd == 8'hFF) edges_fs++;
      end
    end
    prev_vs = vs;
  endtask

  task automatic idle(input int n);
    repeat (n) step(8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic run_frame(input int rst_row);
    int hb;
    build_expected();
    idle(2);
    step(8'h00, 1'b0, 1'b1, 1'b0, 8'h00);
    step(8'h00, 1'b0, 1'b1, 1'b0, 8'h00);
    idle(3);
    for (int y = 0; y < fh; y++) begin
      hb = $urandom_range(2, 5);
      for (int b = 0; b < hb; b++) step(8'h00, (b == 0), 1'b0, 1'b0, 8'h00);
      for (int x = 0; x < fw; x++) begin
        if (y == rst_row && x == fw / 2) begin
          mute = 1'b1;
          data_q.delete();
          cnt_q.delete();
          cnt_dc   = 1'b1;
          edges_fs = 0;
          rst_n    = 1'b0;
          rst_hold = 4;
        end
        step(frm[y][x], 1'b0, 1'b0, 1'b1, expo[y][x]);
      end
    end
    idle(4);
    if (mute) begin
      idle(6);
      mute = 1'b0;
    end
  endtask

  // Monitor: output at this negedge answers the input driven three clocks earlier.
  logic [2:0] mon_s;
  logic [7:0] mon_d;
  int         mon_c;
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_edge_data", int'(edge_data), 0);
      chk("rst_sync", int'({edge_hs, edge_vs, edge_de}), 0);
`ifdef HYST_EDGE_CNT_EN
      chk("rst_edge_cnt", int'(edge_cnt), 0);
      chk("rst_edge_cnt_vld", int'(edge_cnt_vld), 0);
`endif
    end
    while (sync_q.size() >= 4) begin
      mon_s = sync_q.pop_front();
      if (!mute && rst_n) chk("sync_hs_vs_de", int'({edge_hs, edge_vs, edge_de}), int'(mon_s));
    end
    if (!mute && rst_n) begin
      if (edge_de) begin
        if (data_q.size() == 0) begin
          chk("unexpected_pixel", int'(edge_de), 0);
        end else begin
          mon_d = data_q.pop_front();
          chk("edge_data", int'(edge_data), int'(mon_d));
        end
      end else begin
        chk("edge_data_blank", int'(edge_data), 0);
      end
`ifdef HYST_EDGE_CNT_EN
      if (edge_cnt_vld) begin
        if (cnt_q.size() == 0) begin
          chk("unexpected_cnt_vld", int'(edge_cnt_vld), 0);
        end else begin
          mon_c = cnt_q.pop_front();
          if (mon_c >= 0) chk("edge_cnt", int'(edge_cnt), mon_c);
        end
      end
`endif
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle(5);
    rst_n = 1'b1;
    idle(6);
    mute = 1'b0;

    // All-zero full-width frame, also clears both line buffers for the sync burst
    clear_frame(); fw = IMG_W; fh = 3;
    run_frame(-1);

    // Random hs/vs/de with zero data, including overlong de runs
    repeat (10) begin
      repeat ($urandom_range(1, 60))
        step(8'h00, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, 8'h00);
      repeat ($urandom_range(1, 4))
        step(8'h00, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 8'h00);
    end
    idle(4);

    // Threshold boundaries on isolated pixels
    clear_frame(); fw = IMG_W; fh = 8;
    frm[2][5] = 8'd39; frm[2][10] = 8'd40; frm[2][15] = 8'd99; frm[2][20] = 8'd100;
    run_frame(-1);

    // Hysteresis promotion and isolated weak pixel
    clear_frame(); fw = IMG_W; fh = 44;
    frm[5][20] = 8'd60; frm[5][21] = 8'd150; frm[40][40] = 8'd60;
    run_frame(-1);

    // Borders, then a weak top-left pixel that must not see the previous frame's last line
    clear_frame(); fw = IMG_W; fh = 6;
    frm[0][0] = 8'd200; frm[5][IMG_W-1] = 8'd200;
    run_frame(-1);
    clear_frame(); fw = IMG_W; fh = 4;
    frm[0][0] = 8'd60;
    run_frame(-1);

    // Random frames, one with a mid-frame reset followed by a checked frame
    for (int f = 0; f < 6; f++) begin
      clear_frame();
      fw = $urandom_range(8, IMG_W);
      fh = $urandom_range(3, 12);
      for (int y = 0; y < fh; y++)
        for (int x = 0; x < fw; x++)
          case ($urandom_range(0, 3))
            1:       frm[y][x] = 8'($urandom_range(30, 110));
            2:       frm[y][x] = 8'($urandom_range(0, 255));
            default: frm[y][x] = 8'h00;
          endcase
      run_frame((f == 2) ? fh / 2 : -1);
    end

    // Closing frame start flushes the last frame's edge count
    idle(2);
    step(8'h00, 1'b0, 1'b1, 1'b0, 8'h00);
    step(8'h00, 1'b0, 1'b1, 1'b0, 8'h00);
    idle(8);

    chk("data_q_drained", data_q.size(), 0);
`ifdef HYST_EDGE_CNT_EN
    chk("cnt_q_drained", cnt_q.size(), 0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
